// File: rtl/tweakey_round_feeder.sv
// Tweakey round feeder: accepts one {TK2,TK1} tweakey and streams ROUNDS round tweakeys,
// forward for encrypt, reversed (after a silent fast-forward) for decrypt. Option: TWEAKEY_ZEROIZE_EN.
`timescale 1ns/1ps
module tweakey_round_feeder #(
  parameter int              DIM    = 64,
  parameter int              ROUNDS = 16,
  parameter int              ROT    = 7,
  parameter logic [DIM-1:0]  POLY   = 64'h000000000000001B,
  parameter int              RW     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tk_valid,
  output logic               tk_ready,
  input  logic [2*DIM-1:0]   tweakey,
  input  logic               decrypt,
  output logic               rtk_valid,
  input  logic               rtk_ready,
  output logic [DIM-1:0]     rtk,
  output logic [RW-1:0]      rtk_round,
  output logic               rtk_last,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, EMIT = 2'd2} state_t;

  localparam logic [RW-1:0] LAST_IDX = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] PREP_END = RW'(ROUNDS - 2);
  localparam logic [RW-1:0] ONE      = RW'(1);

  function automatic logic [DIM-1:0] tk1_fwd(input logic [DIM-1:0] x);
    return (x << ROT) | (x >> (DIM - ROT));
  endfunction

  function automatic logic [DIM-1:0] tk1_inv(input logic [DIM-1:0] x);
    return (x >> ROT) | (x << (DIM - ROT));
  endfunction

  function automatic logic [DIM-1:0] tk2_fwd(input logic [DIM-1:0] x);
    return {x[DIM-2:0], 1'b0} ^ (x[DIM-1] ? POLY : {DIM{1'b0}});
  endfunction

  // POLY[0]=1 so bit 0 of t is always 0; the shifted-out feedback bit returns at the MSB
  function automatic logic [DIM-1:0] tk2_inv(input logic [DIM-1:0] x);
    logic [DIM-1:0] t;
    t = x ^ (x[0] ? POLY : {DIM{1'b0}});
    return {x[0], t[DIM-1:1]};
  endfunction

  function automatic logic [DIM-1:0] round_key(input logic [DIM-1:0] a, input logic [DIM-1:0] b,
                                               input logic [RW-1:0] r);
    return a ^ b ^ {{(DIM-RW){1'b0}}, r};
  endfunction

  state_t          state_r, state_n;
  logic [DIM-1:0]  tk1_r, tk1_n, tk2_r, tk2_n, rtk_r, rtk_n;
  logic [RW-1:0]   cnt_r, cnt_n, round_r, round_n;
  logic            dec_r, dec_n, last_r, last_n, valid_r, valid_n;
  logic            tk_ready_r, busy_r;

  // Next-state and next-output computation
  always_comb begin
    state_n = state_r;
    tk1_n   = tk1_r;
    tk2_n   = tk2_r;
    dec_n   = dec_r;
    cnt_n   = cnt_r;
    rtk_n   = rtk_r;
    round_n = round_r;
    last_n  = last_r;
    valid_n = valid_r;
    case (state_r)
      IDLE: begin
        if (tk_valid && tk_ready_r) begin
          tk1_n = tweakey[DIM-1:0];
          tk2_n = tweakey[2*DIM-1:DIM];
          dec_n = decrypt;
          cnt_n = {RW{1'b0}};
          if (decrypt) begin
            state_n = PREP;
            valid_n = 1'b0;
          end else begin
            state_n = EMIT;
            valid_n = 1'b1;
            rtk_n   = round_key(tk1_n, tk2_n, {RW{1'b0}});
            round_n = {RW{1'b0}};
            last_n  = 1'b0;
          end
        end else begin
          valid_n = 1'b0;
        end
      end
      PREP: begin
        tk1_n = tk1_fwd(tk1_r);
        tk2_n = tk2_fwd(tk2_r);
        if (cnt_r == PREP_END) begin
          state_n = EMIT;
          cnt_n   = LAST_IDX;
          valid_n = 1'b1;
          rtk_n   = round_key(tk1_n, tk2_n, LAST_IDX);
          round_n = LAST_IDX;
          last_n  = 1'b0;
        end else begin
          cnt_n = cnt_r + ONE;
        end
      end
      EMIT: begin
        if (rtk_ready && last_r) begin
          state_n = IDLE;
          valid_n = 1'b0;
          last_n  = 1'b0;
`ifdef TWEAKEY_ZEROIZE_EN
          tk1_n = {DIM{1'b0}};
          tk2_n = {DIM{1'b0}};
          rtk_n = {DIM{1'b0}};
`endif
        end else if (rtk_ready) begin
          if (dec_r) begin
            tk1_n  = tk1_inv(tk1_r);
            tk2_n  = tk2_inv(tk2_r);
            cnt_n  = cnt_r - ONE;
            last_n = (cnt_n == {RW{1'b0}});
          end else begin
            tk1_n  = tk1_fwd(tk1_r);
            tk2_n  = tk2_fwd(tk2_r);
            cnt_n  = cnt_r + ONE;
            last_n = (cnt_n == LAST_IDX);
          end
          rtk_n   = round_key(tk1_n, tk2_n, cnt_n);
          round_n = cnt_n;
        end else begin
          valid_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      tk1_r      <= {DIM{1'b0}};
      tk2_r      <= {DIM{1'b0}};
      dec_r      <= 1'b0;
      cnt_r      <= {RW{1'b0}};
      rtk_r      <= {DIM{1'b0}};
      round_r    <= {RW{1'b0}};
      last_r     <= 1'b0;
      valid_r    <= 1'b0;
      tk_ready_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      tk1_r      <= tk1_n;
      tk2_r      <= tk2_n;
      dec_r      <= dec_n;
      cnt_r      <= cnt_n;
      rtk_r      <= rtk_n;
      round_r    <= round_n;
      last_r     <= last_n;
      valid_r    <= valid_n;
      tk_ready_r <= (state_n == IDLE);
      busy_r     <= (state_n != IDLE);
    end
  end

  assign tk_ready  = tk_ready_r;
  assign rtk_valid = valid_r;
  assign rtk       = rtk_r;
  assign rtk_round = round_r;
  assign rtk_last  = last_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_tweakey_round_feeder.sv
// Self-checking bench for tweakey_round_feeder: directed vectors, random tweakeys with a
// forward-schedule reference model, backpressure, mid-stream reset and end-of-stream register contents.
`timescale 1ns/1ps
module tb_tweakey_round_feeder;
  localparam int DIM = 64;
  localparam int ROUNDS = 16;
  localparam int ROT = 7;
  localparam int RW = 6;
  localparam logic [63:0] POLY = 64'h000000000000001B;

  logic clk = 1'b0, rst_n = 1'b0, tk_valid = 1'b0, decrypt = 1'b0, rtk_ready = 1'b0;
  logic [2*DIM-1:0] tweakey = '0;
  logic tk_ready, rtk_valid, rtk_last, busy;
  logic [DIM-1:0] rtk;
  logic [RW-1:0] rtk_round;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q [ROUNDS];
  int          exp_rnd [ROUNDS];
  logic [63:0] obs [ROUNDS];
  logic [63:0] enc_obs [ROUNDS];

  tweakey_round_feeder #(.DIM(DIM), .ROUNDS(ROUNDS), .ROT(ROT), .POLY(POLY), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .tk_valid(tk_valid), .tk_ready(tk_ready), .tweakey(tweakey),
    .decrypt(decrypt), .rtk_valid(rtk_valid), .rtk_ready(rtk_ready), .rtk(rtk),
    .rtk_round(rtk_round), .rtk_last(rtk_last), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: walk the forward schedule, then order by direction
  task automatic build_expected(input logic [127:0] tk, input logic dec);
    logic [63:0] a, b;
    logic [63:0] fw [ROUNDS];
    a = tk[63:0];
    b = tk[127:64];
    for (int r = 0; r < ROUNDS; r++) begin
      fw[r] = a ^ b ^ 64'(r);
      a = (a << ROT) | (a >> (64 - ROT));
      b = (b * 64'd2) ^ (b[63] ? POLY : 64'd0);
    end
    for (int r = 0; r < ROUNDS; r++) begin
      exp_q[r]   = dec ? fw[ROUNDS-1-r] : fw[r];
      exp_rnd[r] = dec ? ROUNDS-1-r : r;
    end
  endtask

  task automatic run_stream(input logic [127:0] tk, input logic dec, input int duty, input bit noise);
    int cyc, idx, waitc;
    bit started, done, prev_stall, rdy;
    logic [63:0] prev_rtk;
    logic [RW-1:0] prev_round;
    build_expected(tk, dec);
    waitc = 0;
    while (!tk_ready && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    checks++;
    if (tk_ready !== 1'b1) begin errors++; $display("FAIL tk_ready_wait: got %b exp 1", tk_ready); end
    tk_valid = 1'b1; tweakey = tk; decrypt = dec; rtk_ready = 1'b0;
    @(posedge clk); #1;
    tk_valid = 1'b0; tweakey = {$urandom, $urandom, $urandom, $urandom}; decrypt = $urandom_range(0, 1);
    cyc = 1; idx = 0; started = 0; done = 0; prev_stall = 0; prev_rtk = '0; prev_round = '0;
    while (!done && cyc < 1000) begin
      if (rtk_valid) begin
        if (!started) begin
          started = 1; checks++;
          if (cyc != (dec ? ROUNDS : 1)) begin
            errors++; $display("FAIL latency: got %0d exp %0d", cyc, dec ? ROUNDS : 1);
          end
        end
        if (prev_stall) begin
          checks++;
          if (rtk !== prev_rtk || rtk_round !== prev_round) begin
            errors++; $display("FAIL stall_stable: got %h/%0d exp %h/%0d", rtk, rtk_round, prev_rtk, prev_round);
          end
        end
        checks++;
        if (rtk !== exp_q[idx]) begin errors++; $display("FAIL rtk[%0d]: got %h exp %h", idx, rtk, exp_q[idx]); end
        checks++;
        if (int'(rtk_round) != exp_rnd[idx]) begin
          errors++; $display("FAIL rtk_round[%0d]: got %0d exp %0d", idx, rtk_round, exp_rnd[idx]);
        end
        checks++;
        if (rtk_last !== (idx == ROUNDS-1)) begin
          errors++; $display("FAIL rtk_last[%0d]: got %b exp %b", idx, rtk_last, idx == ROUNDS-1);
        end
        obs[idx] = rtk;
      end else if (started) begin
        checks++; errors++; $display("FAIL valid_drop: got 0 exp 1 at item %0d", idx);
      end
      checks++;
      if (tk_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL busy_stream: got tk_ready=%b busy=%b exp 0/1", tk_ready, busy);
      end
      rdy = ($urandom_range(0, 99) < duty);
      rtk_ready = rdy;
      tk_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tweakey = {$urandom, $urandom, $urandom, $urandom};
      decrypt = $urandom_range(0, 1);
      prev_stall = rtk_valid && !rdy;
      prev_rtk = rtk; prev_round = rtk_round;
      if (rtk_valid && rdy) begin
        idx++;
        if (idx == ROUNDS) done = 1;
      end
      @(posedge clk); #1; cyc++;
    end
    tk_valid = 1'b0; rtk_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL stream_timeout: got %0d handshakes exp %0d", idx, ROUNDS);
    end else if (rtk_valid !== 1'b0 || tk_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL end_of_stream: got valid=%b tk_ready=%b busy=%b exp 0/1/0", rtk_valid, tk_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if (tk_ready !== 1'b0 || rtk_valid !== 1'b0 || busy !== 1'b0 || rtk !== 64'd0 ||
        rtk_round !== 6'd0 || rtk_last !== 1'b0) begin
      errors++; $display("FAIL reset_state: got rdy=%b v=%b busy=%b rtk=%h rnd=%0d last=%b exp all 0",
                         tk_ready, rtk_valid, busy, rtk, rtk_round, rtk_last);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (tk_ready !== 1'b0) begin errors++; $display("FAIL tk_ready_pre_clock: got %b exp 0", tk_ready); end
    @(posedge clk); #1;
    checks++;
    if (tk_ready !== 1'b1) begin errors++; $display("FAIL tk_ready_after_reset: got %b exp 1", tk_ready); end
  endtask

  task automatic test_encrypt_vectors();
    run_stream({64'd0, 64'd1}, 1'b0, 100, 1'b0);
    checks++;
    if (obs[0] !== 64'h1 || obs[1] !== 64'h81 || obs[15] !== 64'h000002000000000F) begin
      errors++; $display("FAIL enc_vec1: got %h %h %h exp 1 81 000002000000000f", obs[0], obs[1], obs[15]);
    end
    run_stream({64'h8000000000000000, 64'd0}, 1'b0, 100, 1'b0);
    checks++;
    if (obs[0] !== 64'h8000000000000000 || obs[1] !== 64'h1A) begin
      errors++; $display("FAIL enc_vec2: got %h %h exp 8000000000000000 1a", obs[0], obs[1]);
    end
  endtask

  task automatic test_decrypt_vectors();
    run_stream({64'd0, 64'd1}, 1'b1, 100, 1'b0);
    checks++;
    if (obs[0] !== 64'h000002000000000F || obs[15] !== 64'h1) begin
      errors++; $display("FAIL dec_vec: got %h %h exp 000002000000000f 1", obs[0], obs[15]);
    end
  endtask

  task automatic test_random_reverse();
    logic [127:0] tk;
    for (int n = 0; n < 100; n++) begin
      tk = {$urandom, $urandom, $urandom, $urandom};
      run_stream(tk, 1'b0, 100, 1'b0);
      for (int r = 0; r < ROUNDS; r++) enc_obs[r] = obs[r];
      run_stream(tk, 1'b1, 100, 1'b0);
      for (int r = 0; r < ROUNDS; r++) begin
        checks++;
        if (obs[r] !== enc_obs[ROUNDS-1-r]) begin
          errors++; $display("FAIL reverse[%0d]: got %h exp %h", r, obs[r], enc_obs[ROUNDS-1-r]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 8; n++)
      run_stream({$urandom, $urandom, $urandom, $urandom}, 1'(n % 2), 30, 1'b1);
  endtask

  task automatic test_midstream_reset();
    int waitc;
    build_expected({64'h0123456789ABCDEF, 64'hFEDCBA9876543210}, 1'b0);
    tk_valid = 1'b1; tweakey = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210}; decrypt = 1'b0;
    @(posedge clk); #1;
    tk_valid = 1'b0; rtk_ready = 1'b1;
    waitc = 0;
    while (!(rtk_valid && rtk_round == 6'd5) && waitc < 40) begin
      @(posedge clk); #1; waitc++;
    end
    checks++;
    if (rtk !== exp_q[5]) begin errors++; $display("FAIL pre_reset_round5: got %h exp %h", rtk, exp_q[5]); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (rtk_valid !== 1'b0 || busy !== 1'b0 || tk_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset: got v=%b busy=%b rdy=%b exp 0/0/0", rtk_valid, busy, tk_ready);
    end
    rtk_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tk_ready !== 1'b1 || rtk_valid !== 1'b0) begin
      errors++; $display("FAIL after_reset_release: got rdy=%b v=%b exp 1/0", tk_ready, rtk_valid);
    end
    run_stream({64'h0123456789ABCDEF, 64'hFEDCBA9876543210}, 1'b0, 100, 1'b0);
  endtask

  task automatic test_end_state();
    run_stream({64'hA5A5A5A5DEADBEEF, 64'h5A5A5A5A0BADF00D}, 1'b0, 100, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
`ifdef TWEAKEY_ZEROIZE_EN
    if (rtk !== 64'd0 || dut.tk1_r !== 64'd0 || dut.tk2_r !== 64'd0) begin
      errors++; $display("FAIL zeroize: got rtk=%h tk1=%h tk2=%h exp 0", rtk, dut.tk1_r, dut.tk2_r);
    end
`else
    if (rtk !== exp_q[ROUNDS-1] || rtk_valid !== 1'b0) begin
      errors++; $display("FAIL hold_last: got rtk=%h v=%b exp %h/0", rtk, rtk_valid, exp_q[ROUNDS-1]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_encrypt_vectors();
    test_decrypt_vectors();
    test_random_reverse();
    test_backpressure();
    test_midstream_reset();
    test_end_state();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tweakey_round_feeder.md
Name: tweakey_round_feeder

Overview:
- Consumer side of the tweakey hash. Accepts one 2*DIM-bit tweakey (TK1 in the low half, TK2 in the high half, matching the hash output packing) over a valid/ready handshake.
- Streams ROUNDS round tweakeys to the cipher datapath over a second valid/ready handshake.
- Encrypt mode emits rounds in forward order. Decrypt mode emits them in reverse order, using inverse schedule steps after a silent fast-forward.

Parameters:
- DIM, 64, width of TK1, TK2 and the round tweakey.
- ROUNDS, 16, number of round tweakeys per tweakey (2..63).
- ROT, 7, TK1 left-rotation per round (1..DIM-1).
- POLY, 64'h000000000000001B, TK2 Galois LFSR feedback mask; bit 0 must be 1.
- RW, 6, round index width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tk_valid  in  1  tweakey offered
- tk_ready  out  1  feeder can accept a tweakey
- tweakey  in  2*DIM  {TK2, TK1}
- decrypt  in  1  sampled with tweakey; 1 = reverse round order
- rtk_valid  out  1  round tweakey valid
- rtk_ready  in  1  datapath accepts round tweakey
- rtk  out  DIM  round tweakey
- rtk_round  out  RW  round index of rtk
- rtk_last  out  1  final round tweakey of this tweakey
- busy  out  1  not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; TK1/TK2 regs=0; tk_ready=0 while in reset, 1 from first clock after release; rtk_valid=0; rtk=0; rtk_round=0; rtk_last=0; busy=0. Reset mid-stream abandons the stream, no further rtk_valid.
- Schedule, forward step:
  - TK1' = rotl(TK1, ROT).
  - TK2' = (TK2<<1) ^ (TK2[DIM-1] ? POLY : 0).
- Schedule, inverse step:
  - TK1 = rotr(TK1', ROT).
  - m = TK2'[0]; TK2 = ((TK2' ^ (m ? POLY : 0)) >> 1) | (m << (DIM-1)).
- Round tweakey: rtk = TK1_r ^ TK2_r ^ zero-extend(r), where r is the round index (0..ROUNDS-1).
- tk_ready = 1 only in IDLE. Accept on tk_valid && tk_ready at a clock edge: latch TK1, TK2 and decrypt, then leave IDLE.
- States:
  - IDLE: wait for accept. Encrypt → EMIT with round counter=0. Decrypt → PREP with step counter=0.
  - PREP: one forward step per cycle for ROUNDS-1 cycles; rtk_valid=0. Then → EMIT with round counter=ROUNDS-1.
  - EMIT: rtk_valid=1; rtk/rtk_round/rtk_last registered and stable while rtk_valid && !rtk_ready.
    - On handshake with a non-last round, advance one step (encrypt: forward, round+1; decrypt: inverse, round-1). Next rtk is presented the following cycle.
    - rtk_last=1 on round ROUNDS-1 (encrypt) or round 0 (decrypt). Handshake on last → IDLE; rtk_valid drops next cycle.
- Latency:
  - Encrypt: first rtk_valid in the cycle after accept.
  - Decrypt: first rtk_valid ROUNDS cycles after accept.
  - Throughput: 1 rtk/cycle under continuous rtk_ready.
- No new tweakey is accepted until the final handshake; tk_ready rises the cycle after it. Back-to-back tweakeys therefore have one idle cycle minimum.
- tweakey/decrypt are ignored when not accepted. The rtk_ready value outside EMIT is don't-care.
- Arithmetic: all XORs are DIM bits; the round counter wraps never (bounded by ROUNDS).

Optional Feature:
- Macro TWEAKEY_ZEROIZE_EN.
- Defined: on the final rtk handshake, TK1/TK2 regs and rtk output reg are cleared to 0 in the same edge as → IDLE. rtk reads 0 while IDLE.
- Undefined: regs retain the last schedule state in IDLE; rtk holds the last value (still qualified by rtk_valid=0).

Test Plan:
- Encrypt, TK1=64'h1, TK2=0, rtk_ready=1 → rounds 0,1 give rtk=64'h1, 64'h81; round 15 gives 64'h0000020000000000^15=64'h000002000000000F with rtk_last=1; 16 consecutive valid cycles.
- Encrypt, TK1=0, TK2=64'h8000000000000000 → round0 rtk=64'h8000000000000000, round1 rtk=64'h1B^1=64'h1A.
- Decrypt, TK1=64'h1, TK2=0 → rtk_valid first high 16 cycles after accept; first rtk=64'h000002000000000F with rtk_round=15; last rtk=64'h1 with rtk_round=0 and rtk_last=1. The sequence equals the encrypt sequence reversed, across 100 random tweakeys.
- Backpressure: random rtk_ready duty 30% → rtk/rtk_round stable whenever valid && !ready; exactly ROUNDS handshakes; tk_ready=0 throughout.
- Reset asserted mid-EMIT (round 5) → rtk_valid=0 and busy=0 immediately (async); tk_ready=1 first clock after release; new encrypt stream starts at round 0.
- TWEAKEY_ZEROIZE_EN defined → after final handshake rtk=0 and internal TK regs=0; undefined → rtk holds the last value.
